// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC access path: scheduler FSM encoding,
// the time-register address table swept by the refresh engine, and the
// PicoBlaze port IDs that the glue logic decodes.
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HOST_ISSUE = 3'd1,
        ST_HOST_WAIT  = 3'd2,
        ST_REF_ISSUE  = 3'd3,
        ST_REF_WAIT   = 3'd4,
        ST_REF_COMMIT = 3'd5
    } rtc_state_t;

    // Time registers in sweep order; index 0 lands in the low byte of the snapshot.
    localparam logic [7:0] RTC_ADDR_SEC   = 8'h21;
    localparam logic [7:0] RTC_ADDR_MIN   = 8'h22;
    localparam logic [7:0] RTC_ADDR_HOUR  = 8'h23;
    localparam logic [7:0] RTC_ADDR_DATE  = 8'h24;
    localparam logic [7:0] RTC_ADDR_MONTH = 8'h25;
    localparam logic [7:0] RTC_ADDR_YEAR  = 8'h26;

    // PicoBlaze port IDs used by the glue that drives host_req/host_*.
    localparam logic [7:0] PORT_RTC_ADDR   = 8'h10;
    localparam logic [7:0] PORT_RTC_WDATA  = 8'h11;
    localparam logic [7:0] PORT_RTC_CTRL   = 8'h12;
    localparam logic [7:0] PORT_RTC_RDATA  = 8'h13;
    localparam logic [7:0] PORT_RTC_STATUS = 8'h14;

    // Sweep index to RTC register address.
    function automatic logic [7:0] rtc_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    return RTC_ADDR_SEC;
            3'd1:    return RTC_ADDR_MIN;
            3'd2:    return RTC_ADDR_HOUR;
            3'd3:    return RTC_ADDR_DATE;
            3'd4:    return RTC_ADDR_MONTH;
            3'd5:    return RTC_ADDR_YEAR;
            default: return RTC_ADDR_SEC;
        endcase
    endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Free-running refresh period counter. Each wrap raises a pending flag that
// the scheduler clears when it starts a sweep; wraps that arrive while the
// flag is already set collapse into it. A wrap on the same cycle as a clear
// wins, so a fresh trigger is never lost.
module rtc_refresh_timer #(
    parameter int unsigned REFRESH_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic pend
);

    localparam int unsigned CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Period counter with wrap-driven pending flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            if (cnt == LAST) begin
                cnt  <= '0;
                pend <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
                if (clear) pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rtc_access_scheduler.sv
// Shares the RTC bus transaction engine between PicoBlaze host accesses and
// a periodic six-register time refresh sweep, committing each complete sweep
// atomically to snap_time. Host requests are served between sweep reads.
// Optional build macro RTC_TIMEOUT_EN adds an engine wait timeout with a
// sticky err flag.
//
// Handshakes: host_req is a level held by the host until it sees the
// one-cycle host_ack; a new request is not accepted on the ack cycle.
// eng_start is a one-cycle pulse with eng_wr/eng_addr/eng_wdata held stable
// until the engine answers with a one-cycle eng_done (eng_rdata valid with it).
module rtc_access_scheduler
    import rtc_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 100_000_000,
    parameter int unsigned NUM_REGS       = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_req,
    input  logic                  host_wr,
    input  logic [7:0]            host_addr,
    input  logic [7:0]            host_wdata,
    output logic                  host_ack,
    output logic [7:0]            host_rdata,
    output logic                  eng_start,
    output logic                  eng_wr,
    output logic [7:0]            eng_addr,
    output logic [7:0]            eng_wdata,
    input  logic                  eng_done,
    input  logic [7:0]            eng_rdata,
    output logic [8*NUM_REGS-1:0] snap_time,
    output logic                  snap_valid,
    output logic                  busy,
    output logic                  err,
    output logic [2:0]            state_dbg
);

    localparam int unsigned IW = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

    rtc_state_t state, state_next;
    logic [IW-1:0] idx;
    logic [NUM_REGS-1:0][7:0] stage;
    logic refresh_pend, pend_clear;
    logic issue_host, issue_ref, host_done, ref_capture, commit;
    logic host_abort, ref_abort, wait_expired;

    rtc_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk  (clk),
        .reset(reset),
        .clear(pend_clear),
        .pend (refresh_pend)
    );

    assign busy      = (state != ST_IDLE);
    assign state_dbg = 3'(state);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state and per-state action strobes; host beats a pending sweep.
    always_comb begin
        state_next  = state;
        issue_host  = 1'b0;
        issue_ref   = 1'b0;
        host_done   = 1'b0;
        ref_capture = 1'b0;
        commit      = 1'b0;
        host_abort  = 1'b0;
        ref_abort   = 1'b0;
        pend_clear  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (host_req && !host_ack)              state_next = ST_HOST_ISSUE;
                else if (refresh_pend || idx != '0)     state_next = ST_REF_ISSUE;
            end
            ST_HOST_ISSUE: begin
                issue_host = 1'b1;
                state_next = ST_HOST_WAIT;
            end
            ST_HOST_WAIT: begin
                if (eng_done) begin
                    host_done  = 1'b1;
                    state_next = ST_IDLE;
                end else if (wait_expired) begin
                    host_abort = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_REF_ISSUE: begin
                issue_ref  = 1'b1;
                pend_clear = (idx == '0);
                state_next = ST_REF_WAIT;
            end
            ST_REF_WAIT: begin
                if (eng_done) begin
                    ref_capture = 1'b1;
                    state_next  = (idx == LAST_IDX) ? ST_REF_COMMIT : ST_IDLE;
                end else if (wait_expired) begin
                    ref_abort  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_REF_COMMIT: begin
                commit     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered engine/host/snapshot outputs, sweep index and staging bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_start  <= 1'b0;
            eng_wr     <= 1'b0;
            eng_addr   <= 8'h00;
            eng_wdata  <= 8'h00;
            host_ack   <= 1'b0;
            host_rdata <= 8'h00;
            snap_time  <= '0;
            snap_valid <= 1'b0;
            idx        <= '0;
            stage      <= '0;
        end else begin
            eng_start  <= 1'b0;
            host_ack   <= 1'b0;
            snap_valid <= 1'b0;
            if (issue_host) begin
                eng_start <= 1'b1;
                eng_wr    <= host_wr;
                eng_addr  <= host_addr;
                eng_wdata <= host_wdata;
            end
            if (issue_ref) begin
                eng_start <= 1'b1;
                eng_wr    <= 1'b0;
                eng_addr  <= rtc_addr(3'(idx));
                eng_wdata <= 8'h00;
            end
            if (host_done) begin
                host_ack <= 1'b1;
                if (!eng_wr) host_rdata <= eng_rdata;
            end
            if (host_abort) begin
                host_ack   <= 1'b1;
                host_rdata <= 8'hFF;
            end
            if (ref_capture) begin
                stage[idx] <= eng_rdata;
                if (idx != LAST_IDX) idx <= idx + 1'b1;
            end
            if (commit) begin
                snap_time  <= stage;
                snap_valid <= 1'b1;
                idx        <= '0;
            end
            if (ref_abort) begin
                stage <= '0;
                idx   <= '0;
            end
        end
    end

`ifdef RTC_TIMEOUT_EN
    localparam int unsigned WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wait_cnt;
    logic          in_wait;

    assign in_wait      = (state == ST_HOST_WAIT) || (state == ST_REF_WAIT);
    assign wait_expired = in_wait && !eng_done && (wait_cnt == WAIT_LAST);

    // Cycles spent waiting on the current engine transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      wait_cnt <= '0;
        else if (in_wait && !eng_done && !wait_expired) wait_cnt <= wait_cnt + 1'b1;
        else                                            wait_cnt <= '0;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        err <= 1'b0;
        else if (host_abort || ref_abort) err <= 1'b1;
    end
`else
    assign wait_expired = 1'b0;
    assign err          = 1'b0;
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    end
`endif

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Bench for rtc_access_scheduler with a short refresh period. An engine model
// answers reads with addr+1 after a programmable delay; a monitor pops expected
// engine transactions, host read data and snapshots as the DUT produces them.
`timescale 1ns/1ps
module tb_rtc_access_scheduler;

    localparam int REF_CYC = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_req = 1'b0, host_wr = 1'b0;
    logic [7:0]  host_addr = 8'h00, host_wdata = 8'h00;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        eng_start, eng_wr;
    logic [7:0]  eng_addr, eng_wdata;
    logic        eng_done = 1'b0;
    logic [7:0]  eng_rdata = 8'h00;
    logic [47:0] snap_time;
    logic        snap_valid, busy, err;
    logic [2:0]  state_dbg;

    int n_total = 0;
    int n_bad   = 0;
    int cyc;
    int stall_once = 0;
    int eng_cnt = 0;
    logic [7:0] eng_lat_addr = 8'h00;

    logic [16:0] exp_q[$];
    logic [47:0] snap_q[$];
    logic [7:0]  rd_q[$];

    localparam logic [47:0] SNAP_EXP = 48'h27_26_25_24_23_22;

    rtc_access_scheduler #(
        .REFRESH_CYCLES(REF_CYC),
        .NUM_REGS      (6),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .host_req  (host_req),
        .host_wr   (host_wr),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_ack  (host_ack),
        .host_rdata(host_rdata),
        .eng_start (eng_start),
        .eng_wr    (eng_wr),
        .eng_addr  (eng_addr),
        .eng_wdata (eng_wdata),
        .eng_done  (eng_done),
        .eng_rdata (eng_rdata),
        .snap_time (snap_time),
        .snap_valid(snap_valid),
        .busy      (busy),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock and cycle count since reset release.
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Engine model: latch on eng_start, answer after 4 cycles (or a one-shot stall).
    initial begin
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (reset) begin
                eng_cnt = 0;
            end else if (eng_start) begin
                eng_lat_addr = eng_addr;
                eng_cnt      = (stall_once != 0) ? stall_once : 4;
                stall_once   = 0;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done  = 1'b1;
                    eng_rdata = eng_lat_addr + 8'h01;
                end
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset) begin
            if (eng_start) begin
                check("eng_start_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0)
                    check("eng_txn", 64'({eng_wr, eng_addr, eng_wdata}), 64'(exp_q.pop_front()));
            end
            if (host_ack) begin
                check("host_ack_expected", 64'(rd_q.size() != 0), 64'd1);
                if (rd_q.size() != 0)
                    check("host_rdata", 64'(host_rdata), 64'(rd_q.pop_front()));
            end
            if (snap_valid) begin
                check("snap_valid_expected", 64'(snap_q.size() != 0), 64'd1);
                if (snap_q.size() != 0)
                    check("snap_time", 64'(snap_time), 64'(snap_q.pop_front()));
            end
        end
    end

    task automatic check_outs_zero(input string tag);
        check({tag, "_snap"}, 64'(snap_time), 64'd0);
        check({tag, "_outs"}, 64'({host_ack, host_rdata, eng_start, eng_wr, eng_addr,
                                   eng_wdata, snap_valid, busy, err}), 64'd0);
    endtask

    task automatic clear_queues();
        exp_q.delete();
        snap_q.delete();
        rd_q.delete();
    endtask

    task automatic start_test(input int stall);
        reset    = 1'b1;
        host_req = 1'b0;
        clear_queues();
        repeat (3) @(negedge clk);
        check_outs_zero("reset");
        stall_once = stall;
        reset      = 1'b0;
    endtask

    task automatic push_reads(input int first, input int last);
        for (int i = first; i <= last; i++)
            exp_q.push_back({1'b0, 8'(8'h21 + i), 8'h00});
    endtask

    task automatic push_sweep();
        push_reads(0, 5);
        snap_q.push_back(SNAP_EXP);
    endtask

    task automatic host_issue(input logic wr, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic [7:0] rd_exp);
        host_req   = 1'b1;
        host_wr    = wr;
        host_addr  = addr;
        host_wdata = wdata;
        exp_q.push_back({wr, addr, wdata});
        rd_q.push_back(rd_exp);
    endtask

    task automatic host_wait_ack(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (host_ack) break;
        end
        check("host_ack_seen", 64'(host_ack), 64'd1);
        host_req = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() + snap_q.size() + rd_q.size() == 0) break;
        end
        check("drain_left", 64'(exp_q.size() + snap_q.size() + rd_q.size()), 64'd0);
    endtask

    task automatic wait_start_addr(input logic [7:0] addr, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (eng_start && eng_addr == addr) break;
        end
        check("saw_start_addr", 64'(eng_start && eng_addr == addr), 64'd1);
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cyc == target) break;
        end
        check("reach_cyc", 64'(cyc), 64'(target));
    endtask

    initial begin
        // Plain sweep: six reads 0x21..0x26 and one coherent snapshot.
        start_test(0);
        push_sweep();
        wait_drain(300);

        // Host write arriving while the idx-2 read is in flight.
        start_test(0);
        push_reads(0, 2);
        wait_start_addr(8'h23, 200);
        host_issue(1'b1, 8'h22, 8'h59, 8'h00);
        push_reads(3, 5);
        snap_q.push_back(SNAP_EXP);
        host_wait_ack(100);
        wait_drain(200);

        // Host request on the same cycle the refresh becomes pending.
        start_test(0);
        wait_cyc(REF_CYC);
        host_issue(1'b0, 8'h30, 8'h00, 8'h31);
        push_sweep();
        host_wait_ack(100);
        wait_drain(200);

        // First read stalls for more than three refresh periods: one extra sweep only.
        start_test(3 * REF_CYC + 12);
        push_sweep();
        push_sweep();
        wait_drain(600);
        wait_cyc(6 * REF_CYC - 1);
        check("idle_after_extra_sweep", 64'(busy), 64'd0);
`ifndef RTC_TIMEOUT_EN
        check("err_tied_low", 64'(err), 64'd0);
`endif

        // Reset in the middle of a sweep at idx 4, then a clean sweep.
        start_test(0);
        push_reads(0, 4);
        wait_start_addr(8'h25, 200);
        repeat (2) @(negedge clk);
        check("mid_sweep_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check_outs_zero("async_reset");
        clear_queues();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_sweep();
        wait_drain(300);

`ifdef RTC_TIMEOUT_EN
        // Engine never answers a host read.
        start_test(100_000);
        host_issue(1'b0, 8'h21, 8'h00, 8'hFF);
        host_wait_ack(1200);
        check("err_after_timeout", 64'(err), 64'd1);
`endif

        reset = 1'b1;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
